aes_rr_arbiter: RTL
===================

// Module: aes_rr_arbiter
// PURPOSE
//  Shares one iterative AES-128 core between two requesters (port 0, port 1) with round-robin
//  arbitration. Latches the winner's key/text/mode, pulses the core start, waits for core done,
//  returns the result to the winner only. Sits between the requesters and the AES core.
// PARAMETERS
//  TIMEOUT_CYC  255  max WAIT cycles before abort (used only with AES_ARB_TIMEOUT_EN)
//  TW           8    width of the timeout counter; TIMEOUT_CYC < 2**TW
// PORTS
//  i_Clk      in   1    clock
//  i_Rst      in   1    synchronous reset, active low
//  i_fReq0    in   1    port 0 request; held high until o_fGnt0
//  i_fEnc0    in   1    port 0 mode: 1 = encrypt, 0 = decrypt
//  i_Key0     in   128  port 0 key
//  i_Text0    in   128  port 0 input block
//  o_fGnt0    out  1    1-cycle pulse: port 0 operands captured
//  o_fDone0   out  1    1-cycle pulse: o_Data0 valid
//  o_fErr0    out  1    1-cycle pulse: port 0 operation aborted by timeout
//  o_Data0    out  128  port 0 result; held until next port 0 completion
//  i_fReq1 .. o_Data1   same set for port 1
//  o_fStart   out  1    core start pulse
//  o_fEnc     out  1    core mode
//  o_Key      out  128  core key
//  o_Text     out  128  core input block
//  i_Data     in   128  core result
//  i_fDone    in   1    core done; level or pulse, rising edge detected here
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; priority pointer = port 0; done-edge register = 0.
//  - All outputs registered. States: IDLE, START, WAIT, RESP.
//  - IDLE: no request -> stay. One request -> that port wins. Both -> pointer port wins.
//    On the edge: latch winner's enc/key/text into o_fEnc/o_Key/o_Text; o_fGntN = 1 and
//    o_fStart = 1 for exactly the next cycle; go START.
//  - START: o_fStart and o_fGntN drop to 0; o_Key/o_Text/o_fEnc held stable; go WAIT.
//  - WAIT: rising edge of i_fDone (i_fDone = 1, previous sample = 0) -> capture i_Data into
//    o_DataN of the owner; o_fDoneN = 1 next cycle; go RESP. No other output changes.
//  - RESP: o_fDoneN back to 0; pointer = other port; go IDLE.
//  - Latency: request seen at edge k -> o_fGnt/o_fStart high in cycle k+1; core done edge at
//    edge m -> o_fDoneN high in cycle m+1; next grant no earlier than 2 cycles after o_fDoneN.
//  - Requests arriving in START/WAIT/RESP wait; never lost, never granted mid-operation.
//  - Request still high after its grant is a new request; the pointer makes the other port
//    win if it is waiting.
//  - i_fDone edges outside WAIT are ignored (done-edge register still tracks i_fDone).
//  - Reset mid-operation: everything returns to reset values immediately; a late core done
//    after reset produces no o_fDone.
//  - o_DataN of the port not being served never changes.
// CONFIGURATION
//  AES_ARB_TIMEOUT_EN defined: TW-bit counter cleared on entry to WAIT, incremented each
//    WAIT cycle. If count reaches TIMEOUT_CYC with no done edge: o_fErrN = 1 for one cycle
//    instead of o_fDoneN, o_DataN unchanged, go RESP (pointer advances as usual).
//    A done edge in the same cycle as the limit wins: normal completion.
//  Not defined: no counter; WAIT lasts until a done edge; o_fErr0/o_fErr1 tied 0.
// TESTING
//  1 Reset with i_Rst=0 for 2 cycles -> all outputs 0; first grant after both requests
//    go high together is port 0.
//  2 Port 0 encrypt, key 5468617473206D79204B756E67204675, text 54776F204F6E65204E696E652054776F
//    -> o_fGnt0/o_fStart 1 cycle after request; o_Data0 = 29C3505F571420F6402299B31A02D73A,
//    o_fDone0 1 cycle after core done edge.
//  3 Port 0 and port 1 both held high continuously (port 1 decrypt of 29C3...D73A, same key)
//    -> grants alternate 0,1,0,1; o_Data1 = 54776F204F6E65204E696E652054776F; each
//    o_fDoneN goes only to the granted port.
//  4 Port 1 raises its request while port 0 is in WAIT -> no o_fStart until port 0 RESP;
//    port 1 granted in the following IDLE; o_Data0 unchanged during port 1 operation.
//  5 i_Rst=0 for 1 cycle during WAIT, then core done arrives -> no o_fDone; next request
//    starts normally, winner chosen with pointer = port 0.
//  6 [AES_ARB_TIMEOUT_EN, TIMEOUT_CYC=16] core i_fDone held low -> o_fErr0 pulse after 16
//    WAIT cycles; o_Data0 keeps its old value; a pending port 1 request is granted next.

Source files
------------

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: round-robin front end that shares one iterative AES-128 core
// between two requesters. It latches the winner's operands, pulses the core
// start and waits for a rising edge on the core done. The result then goes back
// to the winning port only.
// Optional feature macro: AES_ARB_TIMEOUT_EN adds a WAIT watchdog that aborts an
// operation after TIMEOUT_CYC cycles and reports it on o_fErrN.
// Handshake: a requester raises i_fReqN with stable operands and holds it until
// o_fGntN. o_fGntN pulses in the cycle after the operands were captured. The
// o_fDoneN pulse marks the cycle in which o_DataN first holds the new result.
// Debug: o_dbg_state shows the FSM state (0 IDLE, 1 START, 2 WAIT, 3 RESP).
module aes_rr_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TW          = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_fReq0,
  input  logic         i_fEnc0,
  input  logic [127:0] i_Key0,
  input  logic [127:0] i_Text0,
  output logic         o_fGnt0,
  output logic         o_fDone0,
  output logic         o_fErr0,
  output logic [127:0] o_Data0,
  input  logic         i_fReq1,
  input  logic         i_fEnc1,
  input  logic [127:0] i_Key1,
  input  logic [127:0] i_Text1,
  output logic         o_fGnt1,
  output logic         o_fDone1,
  output logic         o_fErr1,
  output logic [127:0] o_Data1,
  output logic         o_fStart,
  output logic         o_fEnc,
  output logic [127:0] o_Key,
  output logic [127:0] o_Text,
  input  logic [127:0] i_Data,
  input  logic         i_fDone,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // An illegal watchdog configuration leaves this marker block in the hierarchy.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TW)) begin : g_bad_timeout_cfg
  end

  state_t       state_q, state_d;
  logic         ptr_q, ptr_d;          // port that wins when both request
  logic         owner_q, owner_d;      // port currently being served
  logic         done_prev_q;           // previous i_fDone sample for edge detect
  logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic         start_q, start_d;
  logic         done0_q, done0_d, done1_q, done1_d;
  logic         enc_q, enc_d;
  logic [127:0] key_q, key_d, text_q, text_d;
  logic [127:0] data0_q, data0_d, data1_q, data1_d;
  logic         any_req, win, done_edge, timeout_hit;

  assign any_req   = i_fReq0 | i_fReq1;
  assign win       = (i_fReq0 & i_fReq1) ? ptr_q : i_fReq1;
  assign done_edge = i_fDone & ~done_prev_q;

`ifdef AES_ARB_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  // The limit is reached when the TIMEOUT_CYC-th WAIT cycle ends without a done edge.
  assign timeout_hit = (cnt_q == TW'(TIMEOUT_CYC - 1));
  assign o_fErr0     = err0_q;
  assign o_fErr1     = err1_q;
`else
  assign timeout_hit = 1'b0;
  assign o_fErr0     = 1'b0;
  assign o_fErr1     = 1'b0;
`endif

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      done_prev_q <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      start_q     <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      enc_q       <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      done_prev_q <= i_fDone;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      start_q     <= start_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      enc_q       <= enc_d;
      key_q       <= key_d;
      text_q      <= text_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
`endif
    end
  end

  // Next-state selection for the IDLE -> START -> WAIT -> RESP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done_edge || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping; pulses default low.
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    start_d = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    enc_d   = enc_q;
    key_d   = key_q;
    text_d  = text_q;
    data0_d = data0_q;
    data1_d = data1_q;
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          start_d = 1'b1;
          enc_d   = win ? i_fEnc1 : i_fEnc0;
          key_d   = win ? i_Key1  : i_Key0;
          text_d  = win ? i_Text1 : i_Text0;
        end
      end
      S_START: begin
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      S_WAIT: begin
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d = cnt_q + TW'(1);
`endif
        // A done edge wins over a watchdog expiry in the same cycle.
        if (done_edge) begin
          if (owner_q) begin
            data1_d = i_Data;
            done1_d = 1'b1;
          end else begin
            data0_d = i_Data;
            done0_d = 1'b1;
          end
        end else if (timeout_hit) begin
`ifdef AES_ARB_TIMEOUT_EN
          err0_d = ~owner_q;
          err1_d = owner_q;
`endif
        end
      end
      S_RESP: begin
        ptr_d = ~owner_q;
      end
      default: begin
      end
    endcase
  end

  assign o_fGnt0     = gnt0_q;
  assign o_fGnt1     = gnt1_q;
  assign o_fStart    = start_q;
  assign o_fDone0    = done0_q;
  assign o_fDone1    = done1_q;
  assign o_fEnc      = enc_q;
  assign o_Key       = key_q;
  assign o_Text      = text_q;
  assign o_Data0     = data0_q;
  assign o_Data1     = data1_q;
  assign o_dbg_state = state_q;

endmodule
